mips_single_cycle_cpu: RTL and testbench

- Single-cycle 32-bit MIPS-subset processor. Top level of the design.
- Contains the fetch unit (PC, instruction memory), register file, ALU, control decode and a byte-addressed data memory.
- One instruction retires per clock edge; there are no branch delay slots.
- Adds a custom conditional branch-and-link instruction, BNEAL.

---
 rtl/cpu_pkg.sv | 75 +++++++
 rtl/mips_single_cycle_cpu_ifu.sv | 45 ++++
 rtl/reg_file.sv | 30 +++
 rtl/mips_single_cycle_cpu.sv | 179 +++++++++++++++++
 tb/tb_mips_single_cycle_cpu.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode/funct constants, ALU operation set and register names for the
// single-cycle MIPS-subset core.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BNEAL = 6'b111111;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_V0   = 5'd2;
  localparam logic [4:0] REG_A0   = 5'd4;
  localparam logic [4:0] REG_A1   = 5'd5;
  localparam logic [4:0] REG_T0   = 5'd8;
  localparam logic [4:0] REG_T1   = 5'd9;
  localparam logic [4:0] REG_S0   = 5'd16;
  localparam logic [4:0] REG_S1   = 5'd17;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  // Shifts operate on b (rt) by sh; LUI places b[15:0] in the upper half.
  function automatic logic [31:0] alu_calc(alu_op_e op, logic [31:0] a,
                                           logic [31:0] b, logic [4:0] sh);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_SLL:  r = b << sh;
      ALU_SRL:  r = b >> sh;
      ALU_SRA:  r = $unsigned($signed(b) >>> sh);
      ALU_LUI:  r = {b[15:0], 16'h0000};
      default:  r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_single_cycle_cpu_ifu.sv
// Fetch unit: PC register and big-endian byte-wide instruction memory.
// Fetches past the end of the memory return 0, which decodes as a NOP.
module ifu #(
  parameter int          IMEM_BYTES = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next_i,
  input  logic        imem_we_i,
  input  logic [31:0] imem_addr_i,
  input  logic [7:0]  imem_wdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  localparam int AW = $clog2(IMEM_BYTES);

  logic [7:0]    imemory [IMEM_BYTES];
  logic [31:0]   pc_q;
  logic [AW-1:0] idx;
  logic          unused_ok;

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_next_i;
  end

  // Program-load port; tied off in the core, contents normally preloaded.
  always_ff @(posedge clk) begin
    if (imem_we_i) imemory[imem_addr_i[AW-1:0]] <= imem_wdata_i;
  end

  always_comb begin
    idx     = pc_q[AW-1:0];
    instr_o = '0;
    if (pc_q <= 32'(IMEM_BYTES - 4))
      instr_o = {imemory[idx], imemory[idx + AW'(1)],
                 imemory[idx + AW'(2)], imemory[idx + AW'(3)]};
  end

  assign pc_o      = pc_q;
  assign unused_ok = ^imem_addr_i[31:AW];

endmodule

// File: rtl/reg_file.sv
// 32x32 register file, two combinational read ports, one clocked write port.
// $0 reads as zero and ignores writes; synchronous active-high reset clears all.
module reg_file
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] rf_q [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (we_i && (wa_i != REG_ZERO)) begin
      rf_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == REG_ZERO) ? 32'h0 : rf_q[ra1_i];
  assign rd2_o = (ra2_i == REG_ZERO) ? 32'h0 : rf_q[ra2_i];

endmodule

// File: rtl/mips_single_cycle_cpu.sv
// Single-cycle MIPS-subset core with the custom BNEAL branch-and-link.
// Define CPU_TRACE_EN to print a per-instruction retire trace in simulation.
module mips_single_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int          IMEM_BYTES = 1024,
  parameter int          DMEM_BYTES = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
);

  localparam int DAW = $clog2(DMEM_BYTES);

  logic [31:0] pc, instr, pc_next, pc_plus4, br_target, j_target;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, wa;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_res, mem_rdata, wb_data;
  logic        reg_we, mem_we, use_imm, zero_ext, wb_mem, wb_link;
  alu_op_e     alu_op;
  logic        unused_ok;

  ifu #(.IMEM_BYTES(IMEM_BYTES), .RESET_PC(RESET_PC)) IFU (
    .clk          (clk),
    .reset        (reset),
    .pc_next_i    (pc_next),
    .imem_we_i    (1'b0),
    .imem_addr_i  (32'h0),
    .imem_wdata_i (8'h00),
    .pc_o         (pc),
    .instr_o      (instr)
  );

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  assign pc_plus4  = pc + 32'd4;
  assign imm_ext   = zero_ext ? {16'h0, imm} : {{16{imm[15]}}, imm};
  assign br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};

  reg_file registers (
    .clk   (clk),
    .reset (reset),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rs_val),
    .rd2_o (rt_val),
    .we_i  (reg_we),
    .wa_i  (wa),
    .wd_i  (wb_data)
  );

  always_comb begin
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    use_imm  = 1'b0;
    zero_ext = 1'b0;
    wb_mem   = 1'b0;
    wb_link  = 1'b0;
    wa       = rd;
    alu_op   = ALU_ADD;
    pc_next  = pc_plus4;
    case (opcode)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          F_ADD, F_ADDU: alu_op = ALU_ADD;
          F_SUB, F_SUBU: alu_op = ALU_SUB;
          F_AND:  alu_op = ALU_AND;
          F_OR:   alu_op = ALU_OR;
          F_XOR:  alu_op = ALU_XOR;
          F_NOR:  alu_op = ALU_NOR;
          F_SLT:  alu_op = ALU_SLT;
          F_SLTU: alu_op = ALU_SLTU;
          F_SLL:  alu_op = ALU_SLL;
          F_SRL:  alu_op = ALU_SRL;
          F_SRA:  alu_op = ALU_SRA;
          F_JR: begin
            reg_we  = 1'b0;
            pc_next = rs_val;
          end
          F_JALR: begin
            wb_link = 1'b1;
            pc_next = rs_val;
          end
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        reg_we  = 1'b1;
        use_imm = 1'b1;
        wa      = rt;
        case (opcode)
          OP_SLTI:  alu_op = ALU_SLT;
          OP_SLTIU: alu_op = ALU_SLTU;
          OP_ANDI:  begin alu_op = ALU_AND; zero_ext = 1'b1; end
          OP_ORI:   begin alu_op = ALU_OR;  zero_ext = 1'b1; end
          OP_XORI:  begin alu_op = ALU_XOR; zero_ext = 1'b1; end
          OP_LUI:   alu_op = ALU_LUI;
          default:  alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        reg_we  = 1'b1;
        use_imm = 1'b1;
        wb_mem  = 1'b1;
        wa      = rt;
      end
      OP_SW: begin
        mem_we  = 1'b1;
        use_imm = 1'b1;
      end
      OP_BEQ: if (rs_val == rt_val) pc_next = br_target;
      OP_BNE: if (rs_val != rt_val) pc_next = br_target;
      OP_BNEAL: begin
        if (rs_val != rt_val) begin
          reg_we  = 1'b1;
          wb_link = 1'b1;
          wa      = REG_RA;
          pc_next = br_target;
        end
      end
      OP_J: pc_next = j_target;
      OP_JAL: begin
        reg_we  = 1'b1;
        wb_link = 1'b1;
        wa      = REG_RA;
        pc_next = j_target;
      end
      default: ;
    endcase
  end

  assign alu_b   = use_imm ? imm_ext : rt_val;
  assign alu_res = alu_calc(alu_op, rs_val, alu_b, shamt);
  assign wb_data = wb_link ? pc_plus4 : (wb_mem ? mem_rdata : alu_res);

  // Little-endian byte memory; word accesses drop the low two address bits.
  logic [7:0]     dmemory [DMEM_BYTES];
  logic [DAW-1:0] dbase;

  assign dbase     = {alu_res[DAW-1:2], 2'b00};
  assign mem_rdata = {dmemory[dbase | DAW'(3)], dmemory[dbase | DAW'(2)],
                      dmemory[dbase | DAW'(1)], dmemory[dbase]};

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      dmemory[dbase]           <= rt_val[7:0];
      dmemory[dbase | DAW'(1)] <= rt_val[15:8];
      dmemory[dbase | DAW'(2)] <= rt_val[23:16];
      dmemory[dbase | DAW'(3)] <= rt_val[31:24];
    end
  end

`ifdef CPU_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      $display("pc=%08h instr=%08h", pc, instr);
      if (reg_we && (wa != REG_ZERO)) $display("  r%0d <= %08h", wa, wb_data);
      if (mem_we) $display("  mem[%08h] <= %08h", {alu_res[31:2], 2'b00}, rt_val);
    end
  end
`endif

  assign pc_out    = pc;
  assign instr_out = instr;
  assign unused_ok = ^{alu_res[31:DAW], alu_res[1:0]};

endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// Bench for mips_single_cycle_cpu: random programs against an ISA-level model,
// a directed trace table, and a fetch-past-end boundary sequence.
module tb_mips_single_cycle_cpu;
  import cpu_pkg::*;

  localparam int IMEM = 1024;
  localparam int DMEM = 1024;
  localparam int NRND = 150;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_out, instr_out;
  int          total = 0;
  int          bad = 0;

  mips_single_cycle_cpu #(.IMEM_BYTES(IMEM), .DMEM_BYTES(DMEM), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_out    (pc_out),
    .instr_out (instr_out)
  );

  always #5 clk = ~clk;

  logic [31:0] m_reg [32];
  logic [7:0]  m_mem [DMEM];
  logic [31:0] m_imem [IMEM/4];
  logic [31:0] m_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_type(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rd, logic [4:0] sh);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_type(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] dreg(int i);
    return dut.registers.rf_q[i];
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < IMEM; i++) dut.IFU.imemory[i] = 8'h00;
    for (int i = 0; i < IMEM/4; i++) m_imem[i] = 32'h0;
  endtask

  task automatic load_word(input int addr, input logic [31:0] w);
    dut.IFU.imemory[addr]     = w[31:24];
    dut.IFU.imemory[addr + 1] = w[23:16];
    dut.IFU.imemory[addr + 2] = w[15:8];
    dut.IFU.imemory[addr + 3] = w[7:0];
    m_imem[addr / 4] = w;
  endtask

  // Two reset cycles, then confirm PC and every register read back cleared.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check({tag, "_reset_pc"}, pc_out, 32'h0);
    for (int i = 0; i < 32; i++) check({tag, "_reset_reg"}, dreg(i), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_pc = 32'h0;
  endtask

  // ISA interpreter: executes one instruction at m_pc; reports the register written.
  task automatic model_step(output int wr);
    logic [31:0] ins, a, b, se, ze, npc, addr, wv;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    int          w;
    ins = (m_pc <= 32'(IMEM - 4)) ? m_imem[m_pc >> 2] : 32'h0;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    a  = m_reg[rs];  b = m_reg[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    npc = m_pc + 4;
    w = -1; wv = 32'h0;
    case (op)
      OP_RTYPE: begin
        w = rd;
        case (fn)
          F_ADD, F_ADDU: wv = a + b;
          F_SUB, F_SUBU: wv = a - b;
          F_AND:  wv = a & b;
          F_OR:   wv = a | b;
          F_XOR:  wv = a ^ b;
          F_NOR:  wv = ~(a | b);
          F_SLT:  wv = ($signed(a) < $signed(b)) ? 1 : 0;
          F_SLTU: wv = (a < b) ? 1 : 0;
          F_SLL:  wv = b << sh;
          F_SRL:  wv = b >> sh;
          F_SRA:  wv = $unsigned($signed(b) >>> sh);
          F_JR:   begin w = -1; npc = a; end
          F_JALR: begin wv = m_pc + 4; npc = a; end
          default: w = -1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin w = rt; wv = a + se; end
      OP_SLTI:  begin w = rt; wv = ($signed(a) < $signed(se)) ? 1 : 0; end
      OP_SLTIU: begin w = rt; wv = (a < se) ? 1 : 0; end
      OP_ANDI:  begin w = rt; wv = a & ze; end
      OP_ORI:   begin w = rt; wv = a | ze; end
      OP_XORI:  begin w = rt; wv = a ^ ze; end
      OP_LUI:   begin w = rt; wv = ze * 65536; end
      OP_LW: begin
        addr = ((a + se) & 32'hFFFF_FFFC) % DMEM;
        w = rt;
        wv = {m_mem[addr + 3], m_mem[addr + 2], m_mem[addr + 1], m_mem[addr]};
      end
      OP_SW: begin
        addr = ((a + se) & 32'hFFFF_FFFC) % DMEM;
        for (int k = 0; k < 4; k++) m_mem[addr + k] = b[8*k +: 8];
      end
      OP_BEQ:   if (a == b) npc = m_pc + 4 + se * 4;
      OP_BNE:   if (a != b) npc = m_pc + 4 + se * 4;
      OP_BNEAL: if (a != b) begin w = 31; wv = m_pc + 4; npc = m_pc + 4 + se * 4; end
      OP_J:     npc = {m_pc[31:28] + ((m_pc[27:0] + 28'd4 == 28'd0) ? 4'd1 : 4'd0), ins[25:0], 2'b00};
      OP_JAL: begin
        w = 31; wv = m_pc + 4;
        npc = {(m_pc + 32'd4) >> 28, ins[25:0], 2'b00};
      end
      default: ;
    endcase
    if (w > 0) m_reg[w] = wv;
    wr = (w > 0) ? w : -1;
    m_pc = npc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] rf [13];
    logic [5:0] io [8];
    logic [4:0] r1, r2, r3;
    logic [5:0] bop;
    int k;
    rf = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
           F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA};
    io = '{OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
    r1 = 5'($urandom_range(0, 31));
    r2 = 5'($urandom_range(0, 31));
    r3 = 5'($urandom_range(0, 31));
    k  = $urandom_range(0, 19);
    if (k < 6)
      return r_type(rf[$urandom_range(0, 12)], r1, r2, r3, 5'($urandom_range(0, 31)));
    else if (k < 12)
      return i_type(io[$urandom_range(0, 7)], r1, r2, 16'($urandom));
    else if (k < 14)
      return i_type(OP_SW, REG_ZERO, r2, 16'($urandom_range(0, DMEM - 1)));
    else if (k < 16)
      return i_type(OP_LW, REG_ZERO, r2, 16'($urandom_range(0, DMEM - 1)));
    else if (k < 19) begin
      bop = (k == 16) ? OP_BEQ : ((k == 17) ? OP_BNE : OP_BNEAL);
      if ($urandom_range(0, 2) == 0) r2 = r1;
      return i_type(bop, r1, r2, 16'($urandom_range(0, 3)));
    end
    return ($urandom_range(0, 1) == 0) ? i_type(6'h01, r1, r2, 16'($urandom))
                                       : r_type(6'h3f, r1, r2, r3, 5'd0);
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ins;
    int          chk;
    logic [31:0] val;
    logic [31:0] npc;
  } vec_t;

  vec_t tv [15];

  initial begin
    int wr, steps;

    // ---------------- random program vs model ----------------
    reset = 1'b1;
    clear_imem();
    for (int i = 0; i < NRND; i++) load_word(4 * i, rand_instr());
    for (int i = NRND; i < NRND + 5; i++) load_word(4 * i, i_type(OP_BEQ, REG_ZERO, REG_ZERO, 16'hFFFF));
    for (int i = 0; i < DMEM; i++) begin
      m_mem[i] = 8'($urandom);
      dut.dmemory[i] = m_mem[i];
    end
    do_reset("rnd");
    steps = 0;
    while (m_pc < 32'(4 * NRND) && steps < 3 * NRND + 10) begin
      check("rnd_pc", pc_out, m_pc);
      check("rnd_instr", instr_out, m_imem[m_pc >> 2]);
      model_step(wr);
      @(posedge clk); @(negedge clk);
      if (wr > 0) check("rnd_wb", dreg(wr), m_reg[wr]);
      steps++;
    end
    check("rnd_end_pc", pc_out, m_pc);
    for (int i = 0; i < 32; i++) check("rnd_final_reg", dreg(i), m_reg[i]);
    for (int i = 0; i < DMEM; i += 4)
      check("rnd_final_mem",
            {dut.dmemory[i + 3], dut.dmemory[i + 2], dut.dmemory[i + 1], dut.dmemory[i]},
            {m_mem[i + 3], m_mem[i + 2], m_mem[i + 1], m_mem[i]});

    // ---------------- directed trace table ----------------
    tv[0]  = '{32'd0,  i_type(OP_ADDI, REG_ZERO, REG_S0, 16'd4),       16, 32'd4,  32'd4};
    tv[1]  = '{32'd4,  i_type(OP_ADDI, REG_ZERO, REG_S1, 16'd12),      17, 32'd12, 32'd8};
    tv[2]  = '{32'd8,  r_type(F_SLT, REG_ZERO, REG_S0, REG_T0, 5'd0),  8,  32'd1,  32'd12};
    tv[3]  = '{32'd12, r_type(F_SLT, REG_S0, REG_ZERO, REG_T1, 5'd0),  9,  32'd0,  32'd16};
    tv[4]  = '{32'd16, i_type(OP_SW, REG_S1, REG_S0, 16'd0),           -1, 32'd0,  32'd20};
    tv[5]  = '{32'd20, i_type(OP_LW, REG_S1, REG_A0, 16'd0),           4,  32'd4,  32'd24};
    tv[6]  = '{32'd24, i_type(OP_ADDI, REG_ZERO, REG_A0, 16'd0),       4,  32'd0,  32'd28};
    tv[7]  = '{32'd28, i_type(OP_BNEAL, REG_S0, REG_S1, 16'd2),        31, 32'd32, 32'd40};
    tv[8]  = '{32'd40, i_type(OP_ADDI, REG_ZERO, REG_A1, 16'd2),       5,  32'd2,  32'd44};
    tv[9]  = '{32'd44, i_type(OP_BNEAL, REG_S0, REG_S0, 16'd2),        31, 32'd32, 32'd48};
    tv[10] = '{32'd48, i_type(OP_ADDI, REG_ZERO, REG_ZERO, 16'd5),     0,  32'd0,  32'd52};
    tv[11] = '{32'd52, {OP_JAL, 26'd16},                               31, 32'd56, 32'd64};
    tv[12] = '{32'd64, r_type(F_JR, REG_RA, REG_ZERO, REG_ZERO, 5'd0), -1, 32'd0,  32'd56};
    tv[13] = '{32'd56, i_type(OP_ADDI, REG_ZERO, REG_V0, 16'd9),       2,  32'd9,  32'd60};
    tv[14] = '{32'd60, i_type(OP_BEQ, REG_ZERO, REG_ZERO, 16'hFFFF),   -1, 32'd0,  32'd60};

    reset = 1'b1;
    @(negedge clk);
    clear_imem();
    for (int i = 0; i < 15; i++) load_word(int'(tv[i].addr), tv[i].ins);
    load_word(32, i_type(OP_ADDI, REG_ZERO, REG_A0, 16'd7));
    load_word(36, i_type(OP_ADDI, REG_ZERO, REG_A0, 16'd7));
    do_reset("dir");
    for (int i = 0; i < 15; i++) begin
      check("vec_pc", pc_out, tv[i].addr);
      check("vec_instr", instr_out, tv[i].ins);
      @(posedge clk); @(negedge clk);
      if (tv[i].chk >= 0) check("vec_reg", dreg(tv[i].chk), tv[i].val);
      check("vec_npc", pc_out, tv[i].npc);
    end
    check("skip_a0", dreg(REG_A0), 32'd0);
    check("keep_a1", dreg(REG_A1), 32'd2);
    check("sw_b12", {24'h0, dut.dmemory[12]}, 32'd4);
    check("sw_b13", {24'h0, dut.dmemory[13]}, 32'd0);
    check("sw_b14", {24'h0, dut.dmemory[14]}, 32'd0);
    check("sw_b15", {24'h0, dut.dmemory[15]}, 32'd0);

    // ---------------- last imem word, then fetch past the end ----------------
    reset = 1'b1;
    clear_imem();
    load_word(0, i_type(OP_ADDI, REG_ZERO, REG_T0, 16'(IMEM - 4)));
    load_word(4, r_type(F_JR, REG_T0, REG_ZERO, REG_ZERO, 5'd0));
    load_word(IMEM - 4, i_type(OP_ADDI, REG_ZERO, REG_T1, 16'd7));
    do_reset("edge");
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("edge_last_pc", pc_out, 32'(IMEM - 4));
    @(posedge clk); @(negedge clk);
    check("edge_last_wb", dreg(REG_T1), 32'd7);
    check("edge_past_pc", pc_out, 32'(IMEM));
    check("edge_past_instr", instr_out, 32'h0);
    @(posedge clk); @(negedge clk);
    check("edge_nop_pc", pc_out, 32'(IMEM + 4));
    check("edge_nop_t1", dreg(REG_T1), 32'd7);
    check("edge_nop_t0", dreg(REG_T0), 32'(IMEM - 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
